// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings, default sizes and the store lane-mask helper
// for the data memory unit.
package dmem_pkg;

  // Mem_Size encodings; 2'b11 is reserved and always faults.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  localparam int DMEM_DEPTH_DEFAULT = 64;
  localparam int DMEM_CNT_W_DEFAULT = 16;

  // Byte lanes touched by a store of the given size at the given byte offset.
  // Misaligned offsets never reach a write; they are filtered as faults first.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] byte_off);
    logic [3:0] m;
    m = 4'b0000;
    case (mem_size_e'(size))
      SIZE_BYTE: m = 4'b0001 << byte_off;
      SIZE_HALF: m = byte_off[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the byte, half or word out of the addressed memory
// word (little-endian lanes) and sign- or zero-extends sub-word results.
// With DMEM_SUBWORD_EN undefined only word loads exist, so the word passes
// straight through and the size/offset/extension inputs are unused.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] load_data
);

`ifdef DMEM_SUBWORD_EN
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Lane select followed by extension according to access size.
  always_comb begin
    byte_val  = rd_word[7:0];
    case (byte_off)
      2'd1:    byte_val = rd_word[15:8];
      2'd2:    byte_val = rd_word[23:16];
      2'd3:    byte_val = rd_word[31:24];
      default: byte_val = rd_word[7:0];
    endcase
    half_val  = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (mem_size_e'(size))
      SIZE_BYTE: load_data = {{24{byte_val[7] & ~load_unsigned}}, byte_val};
      SIZE_HALF: load_data = {{16{half_val[15] & ~load_unsigned}}, half_val};
      default:   load_data = rd_word;
    endcase
  end
`else
  logic unused_sub;
  assign unused_sub = ^{byte_off, size, load_unsigned};
  assign load_data  = rd_word;
`endif

endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: word-addressed data memory for the single-cycle MIPS
// datapath. Loads are combinational (zero latency); stores, fault capture
// and the saturating store counter update on the rising clock edge.
// Optional feature macro: DMEM_SUBWORD_EN enables byte/half accesses; when
// undefined only word accesses are legal and byte/half sizes fault.
//
// There is no handshake: an access is presented with Mem_Read/Mem_Write for
// one cycle and completes in that cycle. Addr_Error qualifies the current
// access; a faulting access neither writes memory nor returns data.
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int CNT_W = DMEM_CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      Addr,
  input  logic [31:0]      Write_Data,
  input  logic             Mem_Read,
  input  logic             Mem_Write,
  input  logic [1:0]       Mem_Size,
  input  logic             Load_Unsigned,
  output logic [31:0]      Read_Data,
  output logic             Addr_Error,
  output logic [31:0]      Bad_Addr,
  output logic             Error_Sticky,
  output logic [CNT_W-1:0] Store_Count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    word_idx;
  logic [1:0]       byte_off;
  logic [31:0]      rd_word;
  logic [31:0]      load_data;
  logic [31:0]      wr_word;
  logic             access;
  logic             size_fault;
  logic             align_fault;
  logic             range_fault;
  logic             fault;
  logic             store_ok;

  logic [31:0]      bad_addr_q, bad_addr_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign word_idx = Addr[AW+1:2];
  assign byte_off = Addr[1:0];
  // Pre-write contents: a same-cycle read+write shows the old word.
  assign rd_word  = mem_q[word_idx];

  // Fault classification of the current access.
  always_comb begin
    size_fault  = 1'b0;
    align_fault = 1'b0;
`ifdef DMEM_SUBWORD_EN
    case (mem_size_e'(Mem_Size))
      SIZE_BYTE: align_fault = 1'b0;
      SIZE_HALF: align_fault = Addr[0];
      SIZE_WORD: align_fault = |Addr[1:0];
      default:   size_fault  = 1'b1;
    endcase
`else
    size_fault  = (Mem_Size != SIZE_WORD);
    align_fault = |Addr[1:0];
`endif
    range_fault = |Addr[31:AW+2];
    access      = Mem_Read | Mem_Write;
    fault       = access & (size_fault | align_fault | range_fault);
    store_ok    = Mem_Write & ~fault;
  end

  dmem_load_align u_load_align (
    .rd_word       (rd_word),
    .byte_off      (byte_off),
    .size          (Mem_Size),
    .load_unsigned (Load_Unsigned),
    .load_data     (load_data)
  );

  assign Read_Data  = (Mem_Read & ~fault) ? load_data : 32'h0;
  assign Addr_Error = fault;

`ifdef DMEM_SUBWORD_EN
  logic [3:0]  wr_mask;
  logic [31:0] wr_lanes;

  // Merge store data into the addressed lanes, keeping the others.
  always_comb begin
    wr_mask = lane_mask(Mem_Size, byte_off);
    case (mem_size_e'(Mem_Size))
      SIZE_BYTE: wr_lanes = {4{Write_Data[7:0]}};
      SIZE_HALF: wr_lanes = {2{Write_Data[15:0]}};
      default:   wr_lanes = Write_Data;
    endcase
    wr_word = rd_word;
    for (int l = 0; l < 4; l++) begin
      if (wr_mask[l]) wr_word[8*l +: 8] = wr_lanes[8*l +: 8];
    end
  end
`else
  assign wr_word = Write_Data;
`endif

  // Next-state for fault capture and the saturating store counter.
  always_comb begin
    bad_addr_d = fault ? Addr : bad_addr_q;
    sticky_d   = sticky_q | fault;
    cnt_d      = cnt_q;
    if (store_ok && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Status registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bad_addr_q <= 32'h0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      bad_addr_q <= bad_addr_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage array: cleared by reset, one word written per successful store.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (store_ok) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  assign Bad_Addr     = bad_addr_q;
  assign Error_Sticky = sticky_q;
  assign Store_Count  = cnt_q;

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Word-addressed data memory with load/store alignment logic for the single-cycle MIPS datapath. It sits directly downstream of the PC/IM/RF/ALU R-type section. The ALU result is the effective address and the register-file rt value is the store data. It returns load data for the write-back mux. It also detects bad accesses, latches the faulting address and counts successful stores.

## Interface
- DEPTH, 64, number of 32-bit words (power of two, 16..1024)
- CNT_W, 16, width of the store counter
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- Addr  in  32  byte address from ALU_Output_Top
- Write_Data  in  32  store data (rt)
- Mem_Read  in  1  load enable
- Mem_Write  in  1  store enable
- Mem_Size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- Load_Unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
- Read_Data  out  32  load result
- Addr_Error  out  1  current access is misaligned, out of range or reserved size
- Bad_Addr  out  32  address of the most recent faulting access
- Error_Sticky  out  1  set on any fault, cleared only by reset
- Store_Count  out  CNT_W  number of successful stores, saturating

## Operation
- Byte ordering is little-endian. Byte lane n occupies bits [8n+7:8n] of the word at index Addr[log2(DEPTH)+1:2].
- A fault is any of the following, provided Mem_Read or Mem_Write is high:
  - half access with Addr[0]=1
  - word access with Addr[1:0]!=0
  - Mem_Size=11
  - Addr >= DEPTH*4
- With no access active, Addr_Error=0.
- Load (Mem_Read=1, no fault):
  - Read_Data is the selected byte, half or word.
  - Sub-word results are extended per Load_Unsigned.
- Read_Data=0 whenever Mem_Read=0 or there is a fault.
- Store (Mem_Write=1, no fault):
  - Only the addressed byte lanes are written, using the low bits of Write_Data.
  - Untouched lanes keep their value.
- On a faulting store, memory is unchanged.
- On a fault at a clock edge: Bad_Addr<=Addr and Error_Sticky<=1. Every new fault overwrites Bad_Addr.
- Store_Count increments by 1 on each successful store edge. It holds at all-ones; there is no wrap-around.
- Mem_Read and Mem_Write both high: the write commits at the edge, and Read_Data shows the pre-write contents during that cycle.

## Timing
- Read path is combinational from Addr, Mem_Size, Load_Unsigned and Mem_Read to Read_Data and Addr_Error, with zero-cycle latency. This is required by the single-cycle datapath.
- Writes, Bad_Addr, Error_Sticky and Store_Count update on the rising edge of CLK.
- A load issued in the cycle after a store to the same address returns the new data.
- Reset values (async, RST=0): every memory word 0, Bad_Addr 0, Error_Sticky 0, Store_Count 0. Read_Data and Addr_Error follow from the inputs and cleared memory.
- Reset asserted mid-access discards that access. No write occurs, and the counter does not count it.
- There is no handshake. Every access completes in the cycle it is presented.

## Configuration
- DMEM_SUBWORD_EN
  - Defined: byte and half accesses are supported as described above.
  - Undefined: only word accesses are legal. Mem_Size 00 and 01 are treated as faults, exactly like 11. Load_Unsigned is ignored, and the lane-merge and extension logic is omitted.

## Structure
- Package dmem_pkg holds:
  - Mem_Size encodings: SIZE_BYTE, SIZE_HALF, SIZE_WORD
  - default DEPTH and CNT_W constants
  - a function computing the byte-lane write mask from Mem_Size and Addr[1:0]
- One sub-module, dmem_load_align: combinational extraction of byte/half/word from the read word, plus sign/zero extension.
- Storage array, fault registers and counter stay in the top.

## Test plan
- Reset, then read Addr=0x10 as a word -> Read_Data=0x00000000, Addr_Error=0, Store_Count=0.
- SW 0xDEADBEEF to 0x08, then next cycle LW 0x08 -> 0xDEADBEEF, Store_Count=1.
- With 0xDEADBEEF at 0x08:
  - LB 0x0B signed -> 0xFFFFFFDE
  - LBU 0x0B -> 0x000000DE
  - LH 0x08 -> 0xFFFFBEEF
  - SB 0x55 to 0x09, then LW 0x08 -> 0xDEAD55EF
- SW to 0x06 -> Addr_Error=1, memory unchanged, Bad_Addr=0x00000006, Error_Sticky=1, Store_Count unchanged. A later good access keeps Error_Sticky=1.
- LW at 0x100 with DEPTH=64 -> fault and Read_Data=0. Assert RST mid-store -> no write, all registers at 0.
- Build without DMEM_SUBWORD_EN: LB 0x08 -> Addr_Error=1, Read_Data=0.
